// File: rtl/ads5296_pkg.sv
// ads5296_pkg: shared state encoding and constants for ADS5296 frame alignment
package ads5296_pkg;
  typedef enum logic [2:0] {IDLE, SETTLE, CHECK, NEXT, SLIP_HI, SLIP_LO, LOCKED, FAIL} state_t;
  localparam logic [9:0] FRAME_PATTERN_DEF = 10'b1111100000;
  localparam logic [2:0] SLIP_INDEX_MAX = 3'd4;
endpackage

// File: rtl/ads5296_align_cnt.sv
// ads5296_align_cnt: loadable down-counter that saturates at zero and flags terminal count
module ads5296_align_cnt #(
  parameter int W = 6
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         done
);
  logic [W-1:0] cnt;
  always_ff @(posedge clk or posedge rst)
    if (rst) cnt <= '0;
    else cnt <= load ? load_val : (cnt != '0 ? cnt - W'(1) : cnt);
  assign done = cnt == '0;
endmodule

// File: rtl/ads5296_frame_align.sv
// ads5296_frame_align: sweeps word-capture phase and bitslip until the frame lane
// repeatedly matches FRAME_PATTERN, then monitors for loss of lock.
module ads5296_frame_align
  import ads5296_pkg::*;
#(
  parameter logic [9:0] FRAME_PATTERN = FRAME_PATTERN_DEF,
  parameter int SETTLE_CYCLES = 32,
  parameter int MATCH_COUNT   = 16,
  parameter int PULSE_LEN     = 8,
  parameter int MAX_SWEEPS    = 4,
  parameter int LOSS_THRESH   = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [9:0] frame_word,
  input  logic       frame_valid,
  output logic       bitslip,
  output logic [2:0] slip_index,
  output logic       locked,
  output logic       fail,
  output logic [2:0] sweeps,
  output logic       busy
);
  localparam int TW = $clog2(SETTLE_CYCLES > PULSE_LEN ? SETTLE_CYCLES : PULSE_LEN) + 1;
  localparam int MW = $clog2(MATCH_COUNT) + 1;
  localparam int SW = $clog2(MAX_SWEEPS) + 1;
  localparam int LW = $clog2(LOSS_THRESH) + 1;
  state_t state, state_n;
  logic [MW-1:0] match_cnt, match_n;
  logic [LW-1:0] loss_cnt, loss_n;
  logic [SW-1:0] sweep_cnt, sweep_n;
  logic [2:0] idx_n;
  logic [TW-1:0] t_val;
  logic hit, miss, restart, t_load, t_done;
  assign hit = frame_valid && frame_word == FRAME_PATTERN;
  assign miss = frame_valid && frame_word != FRAME_PATTERN;
  assign restart = start && (state == IDLE || state == LOCKED || state == FAIL);
  always_comb begin
    state_n = state;
    match_n = '0;
    loss_n = '0;
    sweep_n = sweep_cnt;
    idx_n = slip_index;
    case (state)
      SETTLE:  state_n = t_done ? CHECK : SETTLE;
      CHECK: begin
        match_n = hit && match_cnt != MW'(MATCH_COUNT) ? match_cnt + MW'(1) : match_cnt;
        if (match_cnt == MW'(MATCH_COUNT)) state_n = LOCKED;
        else if (miss) begin
          match_n = '0;
          state_n = NEXT;
        end
      end
      NEXT: begin
        idx_n = slip_index < SLIP_INDEX_MAX ? slip_index + 3'd1 : 3'd0;
        sweep_n = slip_index < SLIP_INDEX_MAX || sweep_cnt == SW'(MAX_SWEEPS) ? sweep_cnt : sweep_cnt + SW'(1);
        state_n = slip_index < SLIP_INDEX_MAX ? SETTLE : (sweep_n == SW'(MAX_SWEEPS) ? FAIL : SLIP_HI);
      end
      SLIP_HI: state_n = t_done ? SLIP_LO : SLIP_HI;
      SLIP_LO: state_n = t_done ? SETTLE : SLIP_LO;
      LOCKED: begin
        loss_n = hit ? '0 : (miss && loss_cnt != LW'(LOSS_THRESH) ? loss_cnt + LW'(1) : loss_cnt);
        if (miss && loss_cnt >= LW'(LOSS_THRESH - 1)) begin
          loss_n = '0;
          sweep_n = '0;
          state_n = SETTLE;
        end
      end
      default: state_n = state;
    endcase
    if (restart) begin
      state_n = SETTLE;
      idx_n = '0;
      sweep_n = '0;
      loss_n = '0;
    end
  end
  // Every entry into a timed state reloads the shared timer with that state's length.
  assign t_load = state_n != state && (state_n == SETTLE || state_n == SLIP_HI || state_n == SLIP_LO);
  assign t_val = state_n == SETTLE ? TW'(SETTLE_CYCLES - 1) : TW'(PULSE_LEN - 1);
  ads5296_align_cnt #(.W(TW)) u_cnt (
    .clk(clk),
    .rst(rst),
    .load(t_load),
    .load_val(t_val),
    .done(t_done)
  );
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      match_cnt <= '0;
      loss_cnt <= '0;
      sweep_cnt <= '0;
      slip_index <= '0;
      bitslip <= 1'b0;
      locked <= 1'b0;
      fail <= 1'b0;
      busy <= 1'b0;
    end else begin
      state <= state_n;
      match_cnt <= match_n;
      loss_cnt <= loss_n;
      sweep_cnt <= sweep_n;
      slip_index <= idx_n;
      bitslip <= state_n == SLIP_HI;
      locked <= state_n == LOCKED;
      fail <= state_n == FAIL;
      busy <= !(state_n == IDLE || state_n == LOCKED || state_n == FAIL);
    end
  assign sweeps = 3'(sweep_cnt);
endmodule

// File: tb/tb_ads5296_frame_align.sv
// tb_ads5296_frame_align: randomized alignment scenarios against an attempt-level timing model
module tb_ads5296_frame_align;
  localparam logic [9:0] PAT = 10'b1111100000;
  localparam int SETTLE = 32, MATCH = 16, PULSE = 8, SWEEPS = 4;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0, frame_valid = 1'b1;
  logic [9:0] frame_word, bad_word = 10'h001;
  logic bitslip, locked, fail, busy;
  logic [2:0] slip_index, sweeps;
  int vectors = 0, errors = 0, edges = 0, hi_len = 0, bad_pulses = 0;
  int tgt_idx = 0, tgt_slips = 0, force_mode = 0;
  logic bs_prev = 1'b0, fixed_bad = 1'b0, rand_valid = 1'b0;
  always #5 clk = ~clk;
  ads5296_frame_align dut (
    .clk(clk), .rst(rst), .start(start), .frame_word(frame_word), .frame_valid(frame_valid),
    .bitslip(bitslip), .slip_index(slip_index), .locked(locked), .fail(fail),
    .sweeps(sweeps), .busy(busy)
  );
  // Source model: the lane shows the pattern only at the chosen phase after the chosen number of slips.
  assign frame_word = force_mode == 2 ? PAT : force_mode == 1 ? bad_word :
                      (int'(slip_index) == tgt_idx && edges == tgt_slips) ? PAT : bad_word;
  function automatic logic [9:0] rnd_bad();
    logic [9:0] w;
    do w = 10'($urandom); while (w == PAT);
    return w;
  endfunction
  always @(negedge clk) begin
    if (bitslip && !bs_prev) edges++;
    if (bitslip) hi_len++;
    else begin
      if (bs_prev && hi_len != PULSE) bad_pulses++;
      hi_len = 0;
    end
    bs_prev = bitslip;
    bad_word = fixed_bad ? 10'h155 : rnd_bad();
    frame_valid = rand_valid ? ($urandom_range(0, 9) < 7) : 1'b1;
  end
  // Cycles from SETTLE entry to locked (or fail): each failed attempt costs settle + check + next,
  // a wrap past phase 4 adds a full slip pulse, a successful attempt costs settle + matches + 1.
  function automatic int model(input int s_tgt, input int i_tgt, output bit to_fail);
    int t = 0;
    to_fail = 1'b1;
    for (int s = 0; s < SWEEPS; s++)
      for (int i = 0; i < 5; i++) begin
        if (s == s_tgt && i == i_tgt) begin
          to_fail = 1'b0;
          return t + SETTLE + MATCH + 1;
        end
        if (i == 4 && s == SWEEPS - 1) return t + SETTLE + 2;
        t += SETTLE + 2 + (i == 4 ? 2 * PULSE : 0);
      end
    return t;
  endfunction
  task automatic apply_reset();
    rst = 1'b1;
    start = 1'b0;
    force_mode = 0;
    repeat (2) @(negedge clk);
    edges = 0;
    bad_pulses = 0;
    rst = 1'b0;
    @(negedge clk);
  endtask
  task automatic do_start();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
  endtask
  task automatic wait_done(input int limit, input bit poke, output int cyc);
    cyc = 0;
    while (!locked && !fail && cyc < limit) begin
      @(negedge clk);
      cyc++;
      start = poke && cyc == 10;
    end
    start = 1'b0;
  endtask
  task automatic test_reset();
    apply_reset();
    vectors++;
    if ({bitslip, locked, fail, busy, slip_index, sweeps} !== 10'd0) begin
      errors++;
      $display("FAIL reset_outputs: got %b expected 0", {bitslip, locked, fail, busy, slip_index, sweeps});
    end
  endtask
  task automatic test_align(input int s, input int i, input bit rv, input bit poke);
    int cyc, exp;
    bit f;
    apply_reset();
    tgt_slips = s;
    tgt_idx = i;
    rand_valid = rv;
    exp = model(s, i, f);
    do_start();
    wait_done(5000, poke, cyc);
    rand_valid = 1'b0;
    vectors++;
    if (!rv && cyc !== exp) begin errors++; $display("FAIL lock_time s=%0d i=%0d: got %0d expected %0d", s, i, cyc, exp); end
    vectors++;
    if ({locked, fail, busy} !== 3'b100) begin errors++; $display("FAIL lock_flags s=%0d i=%0d: got %b expected 100", s, i, {locked, fail, busy}); end
    vectors++;
    if (slip_index !== 3'(i)) begin errors++; $display("FAIL lock_index: got %0d expected %0d", slip_index, i); end
    vectors++;
    if (sweeps !== 3'(s)) begin errors++; $display("FAIL lock_sweeps: got %0d expected %0d", sweeps, s); end
    vectors++;
    if (edges !== s || bad_pulses !== 0) begin errors++; $display("FAIL slip_pulses: got %0d edges %0d bad expected %0d edges 0 bad", edges, bad_pulses, s); end
  endtask
  task automatic test_never_matches();
    int cyc, exp;
    bit f;
    apply_reset();
    fixed_bad = 1'b1;
    tgt_slips = 99;
    exp = model(99, 0, f);
    do_start();
    wait_done(5000, 1'b0, cyc);
    vectors++;
    if (cyc !== exp) begin errors++; $display("FAIL fail_time: got %0d expected %0d", cyc, exp); end
    vectors++;
    if ({fail, locked, busy} !== 3'b100) begin errors++; $display("FAIL fail_flags: got %b expected 100", {fail, locked, busy}); end
    vectors++;
    if (sweeps !== 3'd4 || slip_index !== 3'd0) begin errors++; $display("FAIL fail_counts: got sweeps %0d idx %0d expected 4 0", sweeps, slip_index); end
    vectors++;
    if (edges !== 3 || bad_pulses !== 0) begin errors++; $display("FAIL fail_pulses: got %0d edges %0d bad expected 3 0", edges, bad_pulses); end
    repeat (5) @(negedge clk);
    vectors++;
    if (fail !== 1'b1) begin errors++; $display("FAIL fail_hold: got %b expected 1", fail); end
    fixed_bad = 1'b0;
    tgt_slips = edges;
    tgt_idx = 2;
    exp = model(0, 2, f);
    do_start();
    vectors++;
    if ({fail, busy, sweeps, slip_index} !== 8'b01_000_000) begin errors++; $display("FAIL restart_from_fail: got %b expected 01000000", {fail, busy, sweeps, slip_index}); end
    wait_done(5000, 1'b0, cyc);
    vectors++;
    if (cyc !== exp || locked !== 1'b1 || slip_index !== 3'd2) begin errors++; $display("FAIL relock_after_fail: got %0d cyc locked %b idx %0d expected %0d 1 2", cyc, locked, slip_index, exp); end
  endtask
  task automatic test_loss();
    int cyc, idx;
    idx = $urandom_range(1, 4);
    test_align(1, idx, 1'b0, 1'b0);
    @(negedge clk) force_mode = 1;
    repeat (3) @(negedge clk);
    vectors++;
    if (locked !== 1'b1) begin errors++; $display("FAIL loss_three: got %b expected 1", locked); end
    force_mode = 2;
    @(negedge clk) force_mode = 1;
    repeat (3) @(negedge clk);
    vectors++;
    if (locked !== 1'b1) begin errors++; $display("FAIL loss_cleared: got %b expected 1", locked); end
    @(negedge clk) force_mode = 0;
    vectors++;
    if ({locked, busy, sweeps} !== 5'b01_000 || slip_index !== 3'(idx)) begin errors++; $display("FAIL loss_drop: got %b idx %0d expected 01000 idx %0d", {locked, busy, sweeps}, slip_index, idx); end
    wait_done(5000, 1'b0, cyc);
    vectors++;
    if (cyc !== SETTLE + MATCH + 1 || locked !== 1'b1 || slip_index !== 3'(idx) || sweeps !== 3'd0) begin
      errors++;
      $display("FAIL relock: got %0d cyc locked %b idx %0d sweeps %0d expected %0d 1 %0d 0", cyc, locked, slip_index, sweeps, SETTLE + MATCH + 1, idx);
    end
    do_start();
    vectors++;
    if ({locked, busy, slip_index} !== 5'b01_000) begin errors++; $display("FAIL restart_from_lock: got %b expected 01000", {locked, busy, slip_index}); end
  endtask
  task automatic test_reset_mid_pulse();
    int n = 0, e0;
    apply_reset();
    fixed_bad = 1'b1;
    tgt_slips = 99;
    do_start();
    while (!bitslip && n < 2000) begin @(negedge clk); n++; end
    vectors++;
    if (bitslip !== 1'b1) begin errors++; $display("FAIL pulse_seen: got %b expected 1", bitslip); end
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    vectors++;
    if ({bitslip, locked, fail, busy, slip_index, sweeps} !== 10'd0) begin errors++; $display("FAIL reset_mid_pulse: got %b expected 0", {bitslip, locked, fail, busy, slip_index, sweeps}); end
    @(negedge clk);
    e0 = edges;
    @(negedge clk) rst = 1'b0;
    repeat (4) @(negedge clk);
    vectors++;
    if (edges !== e0 || bitslip !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL release_quiet: got edges %0d bitslip %b busy %b expected %0d 0 0", edges, bitslip, busy, e0); end
    fixed_bad = 1'b0;
  endtask
  initial begin
    test_reset();
    test_align(0, 0, 1'b0, 1'b0);
    test_align(0, 3, 1'b0, 1'b0);
    test_align(1, 0, 1'b0, 1'b0);
    test_align(0, 1, 1'b0, 1'b1);
    for (int k = 0; k < 4; k++) test_align($urandom_range(0, 3), $urandom_range(0, 4), 1'b0, k[0]);
    for (int k = 0; k < 3; k++) test_align($urandom_range(0, 3), $urandom_range(0, 4), 1'b1, 1'b0);
    test_never_matches();
    test_loss();
    test_reset_mid_pulse();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
